// File: rtl/noc_pkg.sv
// noc_pkg: shared flow-control, preamble and framing types for router ports.
package noc_pkg;
  typedef enum logic {kFlowControlAckNack, kFlowControlCredit} noc_flow_control_t;
  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;
  typedef enum logic {kFrIdle, kFrBody} framing_state_t;
  parameter int PortQueueDepth = 4;
  // Offsets of the preamble bits below the flit MSB.
  localparam int HeadBit = 0;
  localparam int TailBit = 1;
  function automatic int credits_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/noc_framing_checker.sv
// noc_framing_checker: head/tail sequence tracker with a sticky violation flag.
module noc_framing_checker
  import noc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      valid,
  input  preamble_t preamble,
  output logic      framing_err
);
  framing_state_t state_q, state_d;
  logic err_q, err_d;
  // A head is only legal between packets, a non-head only inside one.
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    if (valid) begin
      err_d = err_q | (preamble.head == (state_q == kFrBody));
      state_d = ((state_q == kFrIdle && !preamble.head) || preamble.tail) ? kFrIdle : kFrBody;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= kFrIdle;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
    end
  end
  assign framing_err = err_q;
endmodule

// File: rtl/noc_port_queue_fc.sv
// noc_port_queue_fc: FWFT router input queue with stop or credit backpressure.
module noc_port_queue_fc
  import noc_pkg::*;
#(
  parameter int                FlitWidth    = 64,
  parameter int                Depth        = PortQueueDepth,
  parameter noc_flow_control_t FlowControl  = kFlowControlAckNack,
  parameter bit                CheckFraming = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FlitWidth-1:0]         data_in,
  input  logic                         data_void_in,
  output logic                         stop_out,
  output logic                         credit_out,
  output logic [FlitWidth-1:0]         data_out,
  output logic                         data_void_out,
  input  logic                         stop_in,
  output logic [$clog2(Depth+1)-1:0]   count_out,
  output logic                         overflow_err,
  output logic                         framing_err
);
  localparam int CW = credits_width(Depth);
  localparam int PW = $clog2(Depth);
  logic [FlitWidth-1:0] mem_q [Depth];
  logic [FlitWidth-1:0] mem_d [Depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic credit_q, credit_d, overflow_q, overflow_d;
  logic push, pop, full, empty, accept;
  assign push = !data_void_in;
  assign empty = count_q == '0;
  assign full = count_q == CW'(Depth);
  assign pop = !empty && !stop_in;
  // A full queue still accepts when the head leaves in the same cycle.
  assign accept = push && (!full || pop);
  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[wr_ptr_q] = data_in;
    wr_ptr_d = accept ? ((wr_ptr_q == PW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? ((rd_ptr_q == PW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d = count_q + CW'(accept) - CW'(pop);
    credit_d = (FlowControl == kFlowControlCredit) && pop;
    overflow_d = overflow_q | (push && !accept);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      credit_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      credit_q <= credit_d;
      overflow_q <= overflow_d;
    end
  end
  assign data_out = mem_q[rd_ptr_q];
  assign data_void_out = empty;
  assign count_out = count_q;
  assign stop_out = (FlowControl == kFlowControlAckNack) && full;
  assign credit_out = credit_q;
  assign overflow_err = overflow_q;
  if (CheckFraming) begin : g_framing
    preamble_t pre;
    assign pre = '{head: data_in[FlitWidth-1-HeadBit], tail: data_in[FlitWidth-1-TailBit]};
    noc_framing_checker u_framing (
      .clk(clk),
      .rst(rst),
      .valid(accept),
      .preamble(pre),
      .framing_err(framing_err)
    );
  end else begin : g_no_framing
    assign framing_err = 1'b0;
  end
endmodule
